// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared widths, general-call address and FSM state codes for the I2C target
package i2c_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam logic [ADDR_W-1:0] GEN_CALL_ADDR = 7'h00;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_WAIT      = 4'd9;

  // Addressed means past our address ACK and not yet released by STOP, NACK or abandon.
  function automatic logic isBusy(input logic [3:0] st);
    return !(st == ST_IDLE || st == ST_WAIT || st == ST_ADDR);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - 2-FF synchroniser plus FILTER-cycle stability filter with edge pulses
module i2c_line_filter #(
  parameter int FILTER = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic lineIn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] stableCnt;

  // A new level must be seen for FILTER consecutive cycles; any return to the old level restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync      <= 2'b11;
      level     <= 1'b1;
      rise      <= 1'b0;
      fall      <= 1'b0;
      stableCnt <= '0;
    end else begin
      sync <= {sync[0], lineIn};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        stableCnt <= '0;
      end else if (stableCnt == CW'(FILTER - 1)) begin
        level     <= sync[1];
        rise      <= sync[1];
        fall      <= ~sync[1];
        stableCnt <= '0;
      end else begin
        stableCnt <= stableCnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target exposing an 8-bit register bank to a bus controller and a CPU port
// Optional SCL-low watchdog enabled by defining I2C_TARGET_TIMEOUT_EN.
module i2c_target import i2c_pkg::*; #(
  parameter logic [ADDR_W-1:0] DEV_ADDR = 7'h50,
  parameter int REGS    = 16,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 3500000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    SCLin,
  input  logic                    SDAin,
  output logic                    SDAlow,
  input  logic                    cpuSel,
  input  logic                    cpuWr,
  input  logic [$clog2(REGS)-1:0] cpuAddr,
  input  logic [DATA_W-1:0]       cpuWData,
  output logic [DATA_W-1:0]       cpuRData,
  output logic                    wrEvent,
  output logic [$clog2(REGS)-1:0] wrIndex,
  output logic                    busy
);

  localparam int IDX_W = $clog2(REGS);

  logic sclLvl, sclRise, sclFall;
  logic sdaLvl, sdaRise, sdaFall;

  i2c_line_filter #(.FILTER(FILTER)) sclFilter (
    .clock  (clock),
    .reset  (reset),
    .lineIn (SCLin),
    .level  (sclLvl),
    .rise   (sclRise),
    .fall   (sclFall)
  );

  i2c_line_filter #(.FILTER(FILTER)) sdaFilter (
    .clock  (clock),
    .reset  (reset),
    .lineIn (SDAin),
    .level  (sdaLvl),
    .rise   (sdaRise),
    .fall   (sdaFall)
  );

  logic [3:0]        state;
  logic [3:0]        bitCnt;
  logic [DATA_W-1:0] shiftReg;
  logic [IDX_W-1:0]  ptr;
  logic              rwBit;
  logic [DATA_W-1:0] regs [REGS];

  logic              startEv, stopEv, timedOut, addrHit;
  logic [DATA_W-1:0] shiftNext;
  logic [IDX_W-1:0]  ptrNext;

  assign startEv   = sdaFall & sclLvl;
  assign stopEv    = sdaRise & sclLvl;
  assign shiftNext = {shiftReg[DATA_W-2:0], sdaLvl};
  assign ptrNext   = ptr + IDX_W'(1);
  assign addrHit   = (shiftReg[DATA_W-1:1] == DEV_ADDR) && (shiftReg[DATA_W-1:1] != GEN_CALL_ADDR);
  assign busy      = isBusy(state);

`ifdef I2C_TARGET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] lowCnt;

  always_ff @(posedge clock) begin
    if (reset || sclLvl || state == ST_IDLE) begin
      lowCnt <= '0;
    end else if (!timedOut) begin
      lowCnt <= lowCnt + TW'(1);
    end
  end

  assign timedOut = !sclLvl && (state != ST_IDLE) && (lowCnt == TW'(TIMEOUT - 1));
`else
  // No watchdog in this build; TIMEOUT is inert and only a negative value could ever trip this.
  assign timedOut = (TIMEOUT < 0);
`endif

  // Bus bits are sampled on filtered SCL rise; SDAlow only moves on the cycle after a filtered SCL fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      ptr      <= '0;
      rwBit    <= 1'b0;
      SDAlow   <= 1'b0;
      wrEvent  <= 1'b0;
      wrIndex  <= '0;
      cpuRData <= '0;
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else begin
      wrEvent <= 1'b0;
      if (startEv) begin
        state  <= ST_ADDR;
        bitCnt <= '0;
      end else if (stopEv) begin
        state  <= ST_IDLE;
        SDAlow <= 1'b0;
      end else if (timedOut) begin
        state  <= ST_IDLE;
        SDAlow <= 1'b0;
        bitCnt <= '0;
      end else if (sclRise) begin
        case (state)
          ST_ADDR, ST_PTR: begin
            shiftReg <= shiftNext;
            bitCnt   <= bitCnt + 4'd1;
          end
          ST_WDATA: begin
            shiftReg <= shiftNext;
            bitCnt   <= bitCnt + 4'd1;
            if (bitCnt == 4'd7) begin
              regs[ptr] <= shiftNext;
              wrEvent   <= 1'b1;
              wrIndex   <= ptr;
              ptr       <= ptrNext;
            end
          end
          ST_RDATA: bitCnt <= bitCnt + 4'd1;
          ST_RDATA_ACK: begin
            if (sdaLvl) state <= ST_WAIT;
            else        ptr   <= ptrNext;
          end
          default: ;
        endcase
      end else if (sclFall) begin
        case (state)
          ST_ADDR: begin
            if (bitCnt == 4'd8) begin
              if (addrHit) begin
                state  <= ST_ADDR_ACK;
                SDAlow <= 1'b1;
                rwBit  <= shiftReg[0];
              end else begin
                state  <= ST_WAIT;
                SDAlow <= 1'b0;
              end
            end
          end
          ST_ADDR_ACK: begin
            bitCnt <= '0;
            if (rwBit) begin
              state    <= ST_RDATA;
              shiftReg <= regs[ptr];
              SDAlow   <= ~regs[ptr][DATA_W-1];
            end else begin
              state  <= ST_PTR;
              SDAlow <= 1'b0;
            end
          end
          ST_PTR: begin
            if (bitCnt == 4'd8) begin
              ptr    <= shiftReg[IDX_W-1:0];
              state  <= ST_PTR_ACK;
              SDAlow <= 1'b1;
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            state  <= ST_WDATA;
            SDAlow <= 1'b0;
            bitCnt <= '0;
          end
          ST_WDATA: begin
            if (bitCnt == 4'd8) begin
              state  <= ST_WDATA_ACK;
              SDAlow <= 1'b1;
            end
          end
          ST_RDATA: begin
            if (bitCnt == 4'd8) begin
              state  <= ST_RDATA_ACK;
              SDAlow <= 1'b0;
            end else begin
              shiftReg <= {shiftReg[DATA_W-2:0], 1'b0};
              SDAlow   <= ~shiftReg[DATA_W-2];
            end
          end
          ST_RDATA_ACK: begin
            state    <= ST_RDATA;
            bitCnt   <= '0;
            shiftReg <= regs[ptr];
            SDAlow   <= ~regs[ptr][DATA_W-1];
          end
          default: ;
        endcase
      end

      // Placed after the bus commit so a same-cycle CPU write to the same register wins.
      if (cpuSel && cpuWr)  regs[cpuAddr] <= cpuWData;
      if (cpuSel && !cpuWr) cpuRData      <= regs[cpuAddr];
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed I2C controller stimulus checked against a register-bank model
module tb_i2c_target;

  localparam int REGS    = 16;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 20;
  localparam int Q       = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl, ctrlSda, sdaBus, SDAlow;
  logic       cpuSel, cpuWr;
  logic [3:0] cpuAddr;
  logic [7:0] cpuWData, cpuRData;
  logic       wrEvent, busy;
  logic [3:0] wrIndex;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [REGS];
  int         mptr;
  int         expIdx[$];

  assign sdaBus = ctrlSda & ~SDAlow;

  always #5 clock = ~clock;

  i2c_target #(.DEV_ADDR(7'h50), .REGS(REGS), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock    (clock),
    .reset    (reset),
    .SCLin    (scl),
    .SDAin    (sdaBus),
    .SDAlow   (SDAlow),
    .cpuSel   (cpuSel),
    .cpuWr    (cpuWr),
    .cpuAddr  (cpuAddr),
    .cpuWData (cpuWData),
    .cpuRData (cpuRData),
    .wrEvent  (wrEvent),
    .wrIndex  (wrIndex),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every commit must match the next index the model queued, and SDAlow must hold while SCL is high.
  logic prevLow;
  int   sclHigh;
  always @(negedge clock) begin
    if (reset) begin
      sclHigh = 0;
      prevLow = SDAlow;
    end else begin
      if (wrEvent) begin
        check("wrEvent expected", int'(expIdx.size() > 0), 1);
        if (expIdx.size() > 0) check("wrIndex", wrIndex, expIdx.pop_front());
      end
      if (sclHigh > FILTER + 4) check("SDAlow stable while SCL high", SDAlow, prevLow);
      sclHigh = scl ? sclHigh + 1 : 0;
      prevLow = SDAlow;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic sendBit(input logic b);
    cyc(Q); ctrlSda = b; cyc(Q); scl = 1'b1; cyc(HALF); scl = 1'b0;
  endtask

  task automatic glitchBit(input logic b);
    cyc(Q); ctrlSda = b; cyc(3);
    scl = 1'b1; cyc(FILTER - 1); scl = 1'b0;
    cyc(Q - 3 - (FILTER - 1)); scl = 1'b1; cyc(HALF); scl = 1'b0;
  endtask

  task automatic recvBit(output logic b);
    cyc(Q); ctrlSda = 1'b1; cyc(Q); scl = 1'b1; cyc(HALF / 2);
    b = sdaBus; cyc(HALF / 2); scl = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    recvBit(ack);
  endtask

  task automatic recvByte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) recvBit(d[i]);
    sendBit(nack);
  endtask

  task automatic startCond();
    cyc(Q); ctrlSda = 1'b1; cyc(Q); scl = 1'b1; cyc(HALF);
    ctrlSda = 1'b0; cyc(HALF); scl = 1'b0;
  endtask

  task automatic stopCond();
    cyc(Q); ctrlSda = 1'b0; cyc(Q); scl = 1'b1; cyc(HALF);
    ctrlSda = 1'b1; cyc(HALF);
  endtask

  task automatic cpuWrite(input int a, input logic [7:0] d);
    cpuSel = 1'b1; cpuWr = 1'b1; cpuAddr = 4'(a); cpuWData = d;
    cyc(1); cpuSel = 1'b0; cpuWr = 1'b0;
    model[a] = d;
  endtask

  task automatic cpuRead(input int a, output logic [7:0] d);
    cpuSel = 1'b1; cpuWr = 1'b0; cpuAddr = 4'(a);
    cyc(1); cpuSel = 1'b0;
    d = cpuRData;
  endtask

  task automatic checkReg(input string name, input int a);
    logic [7:0] d;
    cpuRead(a, d);
    check(name, d, model[a]);
  endtask

  task automatic modelBusWrite(input logic [7:0] d);
    model[mptr] = d;
    expIdx.push_back(mptr);
    mptr = (mptr + 1) % REGS;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d1, d2;
    scl = 1'b1; ctrlSda = 1'b1;
    cpuSel = 1'b0; cpuWr = 1'b0; cpuAddr = '0; cpuWData = '0;
    for (int i = 0; i < REGS; i++) model[i] = 8'h00;
    mptr = 0;
    cyc(4); reset = 1'b0; cyc(2);

    check("reset SDAlow", SDAlow, 0);
    check("reset cpuRData", cpuRData, 0);
    check("reset wrEvent", wrEvent, 0);
    check("reset wrIndex", wrIndex, 0);
    check("reset busy", busy, 0);
    for (int i = 0; i < REGS; i++) begin
      cpuRead(i, d1);
      check("reset reg", d1, 8'h00);
    end

    // Burst write starting at register 3
    startCond();
    sendByte(8'hA0, ack); check("t1 addr ack", ack, 0);
    check("t1 busy addressed", busy, 1);
    sendByte(8'h03, ack); check("t1 ptr ack", ack, 0);
    mptr = 3;
    modelBusWrite(8'h5A); sendByte(8'h5A, ack); check("t1 data0 ack", ack, 0);
    modelBusWrite(8'hC3); sendByte(8'hC3, ack); check("t1 data1 ack", ack, 0);
    stopCond();
    check("t1 busy after stop", busy, 0);
    checkReg("t1 reg3", 3);
    cpuRead(4, d1); check("t1 reg4 literal", d1, 8'hC3);
    check("t1 commits drained", expIdx.size(), 0);

    // Pointer set, repeated start, read across the wrap
    cpuWrite(15, 8'h11);
    cpuWrite(0, 8'h22);
    startCond();
    sendByte(8'hA0, ack); check("t2 addr ack", ack, 0);
    sendByte(8'h0F, ack); check("t2 ptr ack", ack, 0);
    mptr = 15;
    startCond();
    sendByte(8'hA1, ack); check("t2 read addr ack", ack, 0);
    recvByte(d1, 1'b0);
    recvByte(d2, 1'b1);
    check("t2 read0", d1, model[mptr]);
    check("t2 read0 literal", d1, 8'h11);
    mptr = (mptr + 1) % REGS;
    check("t2 read1 wrapped", d2, model[mptr]);
    check("t2 read1 literal", d2, 8'h22);
    cyc(Q);
    check("t2 SDA released", SDAlow, 0);
    check("t2 not busy after nack", busy, 0);
    stopCond();

    // Foreign address must be ignored entirely
    startCond();
    sendByte(8'hA2, ack); check("t3 no addr ack", ack, 1);
    check("t3 busy", busy, 0);
    sendByte(8'h55, ack); check("t3 no data ack", ack, 1);
    check("t3 busy after data", busy, 0);
    stopCond();
    for (int i = 0; i < REGS; i++) checkReg("t3 reg unchanged", i);

    // CPU write coinciding with the bus commit to the same register
    startCond();
    sendByte(8'hA0, ack); check("t4 addr ack", ack, 0);
    sendByte(8'h03, ack); check("t4 ptr ack", ack, 0);
    for (int i = 7; i >= 1; i--) sendBit(d1[0] ^ d1[0] ^ 1'(8'h5A >> i));
    expIdx.push_back(3);
    cpuSel = 1'b1; cpuWr = 1'b1; cpuAddr = 4'd3; cpuWData = 8'h77;
    fork
      sendBit(1'b0);
      begin
        for (int k = 0; k < 200; k++) begin
          if (wrEvent) break;
          cyc(1);
        end
        check("t4 commit seen", wrEvent, 1);
        cpuSel = 1'b0; cpuWr = 1'b0;
      end
    join
    model[3] = 8'h77;
    recvBit(ack); check("t4 data ack", ack, 0);
    stopCond();
    checkReg("t4 cpu wins", 3);
    cpuRead(3, d1); check("t4 reg3 literal", d1, 8'h77);

    // Short SCL glitches during a byte, then a STOP mid-byte
    startCond();
    sendByte(8'hA0, ack); check("t5 addr ack", ack, 0);
    sendByte(8'h06, ack); check("t5 ptr ack", ack, 0);
    mptr = 6;
    modelBusWrite(8'h3C);
    for (int i = 7; i >= 0; i--) glitchBit(1'(8'h3C >> i));
    recvBit(ack); check("t5 glitch data ack", ack, 0);
    stopCond();
    checkReg("t5 reg6", 6);
    cpuRead(6, d1); check("t5 reg6 literal", d1, 8'h3C);
    startCond();
    sendByte(8'hA0, ack); check("t5b addr ack", ack, 0);
    sendByte(8'h07, ack); check("t5b ptr ack", ack, 0);
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    stopCond();
    check("t5b busy after stop", busy, 0);
    checkReg("t5b reg7 untouched", 7);

    // SCL held low after the address ACK
    startCond();
    sendByte(8'hA0, ack); check("t6 addr ack", ack, 0);
    cyc(TIMEOUT + 10);
    check("t6 SDAlow", SDAlow, 0);
`ifdef I2C_TARGET_TIMEOUT_EN
    check("t6 busy abandoned", busy, 0);
`else
    check("t6 busy held", busy, 1);
`endif
    stopCond();
    check("t6 busy after stop", busy, 0);

    // Reset while the address ACK is being driven
    startCond();
    for (int i = 7; i >= 0; i--) sendBit(1'(8'hA0 >> i));
    cyc(Q); ctrlSda = 1'b1; cyc(Q); scl = 1'b1; cyc(HALF / 2);
    check("t7 ack driven", SDAlow, 1);
    reset = 1'b1; cyc(2);
    check("t7 SDAlow after reset", SDAlow, 0);
    check("t7 busy after reset", busy, 0);
    reset = 1'b0;
    for (int i = 0; i < REGS; i++) model[i] = 8'h00;
    mptr = 0;
    cyc(HALF / 2); scl = 1'b0;
    sendByte(8'hA0, ack); check("t7 no ack without start", ack, 1);
    stopCond();
    checkReg("t7 reg3 cleared", 3);

    check("all commits seen", expIdx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
